// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Program counter and next-PC stage of the single-cycle core. It selects the
//   next instruction address from the control decoder's next-PC operation,
//   the register operands and the instruction immediates. It also owns the
//   exit-syscall halt state, the display-syscall latch and the run statistics.
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   en           step enable; all registers hold when low
//   op_wtg       next-PC operation (NOP/J32/J26/BEQ/BNE/BLTZ, others = NOP)
//   syscall_en   current instruction is a syscall
//   data_x       regfile port A (rs, or $v0 during a syscall)
//   data_y       regfile port B (rt, or $a0 during a syscall)
//   imm16        instruction[15:0], branch offset in words
//   imm26        instruction[25:0], jump target in words
//   pc           registered current PC
//   pc_4         pc + 4, combinational
//   branch_taken combinational; conditional branch taken this cycle
//   halted       registered; exit syscall has executed
//   display      registered; last $a0 of a display syscall
//   cycle_cnt    executed instructions
//   jump_cnt     executed j/jal/jr
//   taken_cnt    taken conditional branches
module fetch_pc_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WTG_OP_BIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WTG_OP_BIT-1:0] op_wtg,
  input  logic                  syscall_en,
  input  logic [31:0]           data_x,
  input  logic [31:0]           data_y,
  input  logic [15:0]           imm16,
  input  logic [25:0]           imm26,
  output logic [31:0]           pc,
  output logic [31:0]           pc_4,
  output logic                  branch_taken,
  output logic                  halted,
  output logic [31:0]           display,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      jump_cnt,
  output logic [CNT_W-1:0]      taken_cnt
);

  // Next-PC operation codes shared with the control decoder.
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_NOP  = WTG_OP_BIT'(0);
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_J32  = WTG_OP_BIT'(1);
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_J26  = WTG_OP_BIT'(2);
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_BEQ  = WTG_OP_BIT'(3);
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_BNE  = WTG_OP_BIT'(4);
  localparam logic [WTG_OP_BIT-1:0] WTG_OP_BLTZ = WTG_OP_BIT'(5);

  localparam logic [31:0] SYS_EXIT    = 32'd10;
  localparam logic [31:0] SYS_DISPLAY = 32'd34;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic             r_halted;
  logic [31:0]      r_display;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_jump_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [31:0] w_pc_4;
  logic [31:0] w_br_target;
  logic [31:0] w_j26_target;
  logic [31:0] w_pc_next;
  logic        w_cond;
  logic        w_is_jump;
  logic        w_branch_taken;
  logic        w_sys_exit;
  logic        w_sys_display;

  assign w_pc_4       = r_pc + 32'd4;
  // Word offset sign-extended and scaled to bytes; the add wraps mod 2^32.
  assign w_br_target  = w_pc_4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign w_j26_target = {w_pc_4[31:28], imm26, 2'b00};

  assign w_sys_exit    = syscall_en && (data_x == SYS_EXIT);
  assign w_sys_display = syscall_en && (data_x == SYS_DISPLAY);

  always_comb begin
    w_cond    = 1'b0;
    w_is_jump = 1'b0;
    unique case (op_wtg)
      WTG_OP_J32,
      WTG_OP_J26:  w_is_jump = 1'b1;
      WTG_OP_BEQ:  w_cond    = (data_x == data_y);
      WTG_OP_BNE:  w_cond    = (data_x != data_y);
      WTG_OP_BLTZ: w_cond    = data_x[31];
      default:     ;
    endcase
  end

  // A syscall overrides whatever op_wtg says, so it also masks the branch.
  assign w_branch_taken = (r_state == S_RUN) && !syscall_en && w_cond;

  always_comb begin
    w_pc_next = w_pc_4;
    if (syscall_en) begin
      if (w_sys_exit) w_pc_next = r_pc;
    end else begin
      case (op_wtg)
        WTG_OP_J32:  w_pc_next = data_x;
        WTG_OP_J26:  w_pc_next = w_j26_target;
        WTG_OP_BEQ,
        WTG_OP_BNE,
        WTG_OP_BLTZ: if (w_cond) w_pc_next = w_br_target;
        default:     w_pc_next = w_pc_4;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_pc        <= PC_RESET;
      r_halted    <= 1'b0;
      r_display   <= '0;
      r_cycle_cnt <= '0;
      r_jump_cnt  <= '0;
      r_taken_cnt <= '0;
    end else if (en) begin
      case (r_state)
        S_RUN: begin
          r_pc        <= w_pc_next;
          r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          if (!syscall_en && w_is_jump) r_jump_cnt <= r_jump_cnt + CNT_W'(1);
          if (w_branch_taken) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
          if (w_sys_display) r_display <= data_y;
          if (w_sys_exit) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_4         = w_pc_4;
  assign branch_taken = w_branch_taken;
  assign halted       = r_halted;
  assign display      = r_display;
  assign cycle_cnt    = r_cycle_cnt;
  assign jump_cnt     = r_jump_cnt;
  assign taken_cnt    = r_taken_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_J32  = 3'd1;
  localparam logic [2:0] OP_J26  = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_BNE  = 3'd4;
  localparam logic [2:0] OP_BLTZ = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op_wtg;
  logic        syscall_en;
  logic [31:0] data_x;
  logic [31:0] data_y;
  logic [15:0] imm16;
  logic [25:0] imm26;

  logic [31:0] pc, pc_4, display;
  logic        branch_taken, halted;
  logic [31:0] cycle_cnt, jump_cnt, taken_cnt;

  logic [31:0] pc_b, pc_4_b, display_b;
  logic        branch_taken_b, halted_b;
  logic [3:0]  cycle_cnt_b, jump_cnt_b, taken_cnt_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit u_dut (
    .clk(clk), .rst(rst), .en(en), .op_wtg(op_wtg), .syscall_en(syscall_en),
    .data_x(data_x), .data_y(data_y), .imm16(imm16), .imm26(imm26),
    .pc(pc), .pc_4(pc_4), .branch_taken(branch_taken), .halted(halted),
    .display(display), .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt),
    .taken_cnt(taken_cnt)
  );

  fetch_pc_unit #(.PC_RESET(32'h0000_0100), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .op_wtg(op_wtg), .syscall_en(syscall_en),
    .data_x(data_x), .data_y(data_y), .imm16(imm16), .imm26(imm26),
    .pc(pc_b), .pc_4(pc_4_b), .branch_taken(branch_taken_b), .halted(halted_b),
    .display(display_b), .cycle_cnt(cycle_cnt_b), .jump_cnt(jump_cnt_b),
    .taken_cnt(taken_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic sys, input logic [31:0] x,
                       input logic [31:0] y, input logic [15:0] i16, input logic [25:0] i26);
    op_wtg = op; syscall_en = sys; data_x = x; data_y = y; imm16 = i16; imm26 = i26;
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cyc,
                             input logic [31:0] e_jmp, input logic [31:0] e_tkn);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".cycle"}, cycle_cnt, e_cyc);
    check({tag, ".jump"}, jump_cnt, e_jmp);
    check({tag, ".taken"}, taken_cnt, e_tkn);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0;
    drive(OP_NOP, 1'b0, '0, '0, '0, '0);
    #11 rst = 1'b0;
    #1;
    check_state("reset", 32'h0, 0, 0, 0);
    check("reset.halted", {31'b0, halted}, 32'd0);
    check("reset.display", display, 32'd0);
    check("reset.pc_b", pc_b, 32'h100);

    // Sequential fetch
    en = 1'b1;
    step(); check("nop1.pc", pc, 32'h4);
    step(); check("nop2.pc", pc, 32'h8);
    step(); check_state("nop3", 32'hC, 3, 0, 0);
    step(); check("nop4.pc", pc, 32'h10);

    // BEQ taken backwards: 0x14 + (-4 << 2) = 0x04
    drive(OP_BEQ, 1'b0, 32'd5, 32'd5, 16'hFFFC, '0);
    check("beq.taken_comb", {31'b0, branch_taken}, 32'd1);
    check("beq.pc_4", pc_4, 32'h14);
    step(); check_state("beq", 32'h4, 5, 0, 1);

    drive(OP_NOP, 1'b0, '0, '0, '0, '0);
    repeat (3) step();
    check("back.pc", pc, 32'h10);
    drive(OP_BEQ, 1'b0, 32'd5, 32'd6, 16'hFFFC, '0);
    check("beq_nt.taken_comb", {31'b0, branch_taken}, 32'd0);
    step(); check_state("beq_nt", 32'h14, 9, 0, 1);

    // Jumps
    drive(OP_J32, 1'b0, 32'hF000_0000, '0, '0, '0);
    step(); check_state("j32a", 32'hF000_0000, 10, 1, 1);
    drive(OP_J26, 1'b0, '0, '0, '0, 26'h0000100);
    step(); check_state("j26", 32'hF000_0400, 11, 2, 1);
    drive(OP_J32, 1'b0, 32'h0000_0040, '0, '0, '0);
    step(); check_state("j32b", 32'h40, 12, 3, 1);

    // BLTZ taken / not taken, BNE taken, undefined op
    drive(OP_BLTZ, 1'b0, 32'h8000_0000, '0, 16'h0002, '0);
    check("bltz.taken_comb", {31'b0, branch_taken}, 32'd1);
    step(); check_state("bltz", 32'h4C, 13, 3, 2);
    drive(OP_BLTZ, 1'b0, 32'h7FFF_FFFF, '0, 16'h0002, '0);
    step(); check_state("bltz_nt", 32'h50, 14, 3, 2);
    drive(OP_BNE, 1'b0, 32'd1, 32'd2, 16'h0001, '0);
    step(); check_state("bne", 32'h58, 15, 3, 3);
    drive(3'd7, 1'b0, 32'h1234, 32'h1, 16'h0010, 26'h3FFFFFF);
    step(); check_state("undef", 32'h5C, 16, 3, 3);

    // Enable low: registers hold, combinational outputs still track
    en = 1'b0;
    drive(OP_BEQ, 1'b0, 32'd7, 32'd7, 16'h0004, '0);
    check("hold.taken_comb", {31'b0, branch_taken}, 32'd1);
    check("hold.pc_4", pc_4, 32'h60);
    repeat (4) step();
    check_state("hold", 32'h5C, 16, 3, 3);
    en = 1'b1;

    // Display syscall with a conflicting BNE: syscall wins
    drive(OP_BNE, 1'b1, 32'd34, 32'hDEAD_BEEF, 16'h0010, '0);
    check("sys_disp.taken_comb", {31'b0, branch_taken}, 32'd0);
    step(); check_state("sys_disp", 32'h60, 17, 3, 3);
    check("sys_disp.display", display, 32'hDEAD_BEEF);
    drive(OP_J32, 1'b1, 32'd5, 32'h1111_1111, '0, '0);
    step(); check_state("sys_other", 32'h64, 18, 3, 3);
    check("sys_other.display", display, 32'hDEAD_BEEF);

    // Exit syscall: pc holds, cycle counted once
    drive(OP_NOP, 1'b1, 32'd10, '0, '0, '0);
    step(); check_state("exit", 32'h64, 19, 3, 3);
    check("exit.halted", {31'b0, halted}, 32'd1);

    // Halted: frozen despite taken BNE and enable
    drive(OP_BNE, 1'b0, 32'd1, 32'd2, 16'h0001, '0);
    check("halt.taken_comb", {31'b0, branch_taken}, 32'd0);
    repeat (5) step();
    check_state("halt", 32'h64, 19, 3, 3);
    check("halt.display", display, 32'hDEAD_BEEF);
    check("halt.halted", {31'b0, halted}, 32'd1);
    check("halt.cycle_b", {28'b0, cycle_cnt_b}, 32'd3);

    // Asynchronous reset between edges while halted
    #2 rst = 1'b1;
    #1;
    check_state("areset", 32'h0, 0, 0, 0);
    check("areset.halted", {31'b0, halted}, 32'd0);
    check("areset.display", display, 32'd0);
    check("areset.pc_b", pc_b, 32'h100);
    #1 rst = 1'b0;

    // 4-bit counter wraps after 15
    drive(OP_NOP, 1'b0, '0, '0, '0, '0);
    repeat (15) step();
    check("wrap15.cycle_b", {28'b0, cycle_cnt_b}, 32'd15);
    check("wrap15.pc_b", pc_b, 32'h13C);
    step();
    check("wrap.cycle_b", {28'b0, cycle_cnt_b}, 32'd0);
    check("wrap.cycle", cycle_cnt, 32'd16);
    check("wrap.pc", pc, 32'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
